ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Directly consumes the ID/EX pipeline register outputs: operand values, destination register and funct3.
- Computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles and stalls the front of the pipeline until done.
- Result and destination register go to the EX/MEM register on a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width; also the iteration count of the datapath.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  M-extension op present in EX this cycle (from ID/EX decode).
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data  input  XLEN  operand A (dividend / multiplicand).
- rs2_data  input  XLEN  operand B (divisor / multiplier).
- rd_addr  input  5  destination register of the op.
- flush  input  1  branch/trap kill; aborts the op in flight.
- stall  output  1  hold IF/ID and ID/EX registers.
- done  output  1  one-cycle pulse; result and rd_addr_out valid.
- result  output  XLEN  final value for the selected op.
- rd_addr_out  output  5  latched destination register.

Behaviour:
- Reset (async, any state): state=IDLE; counter, accumulators, result, rd_addr_out=0; done=0; stall=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 & flush=0: latch funct3, rd_addr and the absolute values of the operands, with signedness per funct3.
  - Record the result-negate flags, then go to CALC with counter=0.
  - stall is combinationally 1 in that same cycle.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - counter increments each cycle; after counter reaches XLEN-1, go to DONE.
  - stall=1 throughout CALC.
- DONE:
  - done=1 for exactly one cycle; result registered and sign-corrected; stall=0.
  - Next state is IDLE.
  - start is not accepted in DONE; the pipeline presents the next op one cycle later.
- Latency: start sampled at edge k gives done high in cycle k+XLEN+1, i.e. 33 cycles for XLEN=32.
- Multiply:
  - Full 2*XLEN product.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - Product negated in two's complement over 2*XLEN bits when operand signs differ: MULH both signed, MULHSU rs1 signed only, MULHU none.
- Divide, signed ops:
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
- Divisor zero:
  - Detected in IDLE; go directly to DONE; done in cycle k+1.
  - DIV/DIVU give all ones; REM/REMU give rs1_data.
- Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM):
  - Direct to DONE.
  - DIV gives 0x80000000; REM gives 0.
- Flush:
  - In IDLE or CALC: return to IDLE next edge, no done pulse; stall deasserts combinationally that cycle.
  - In DONE: done still pulses; the downstream EX/MEM register discards it.
- start while in CALC is ignored; the pipeline is stalled, so start is held by design.
- result and rd_addr_out hold their last value until the next DONE.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiply ops use a combinational 2*XLEN multiplier and go IDLE→DONE directly (done in cycle k+1); divide path unchanged.
- Undefined: all ops use the iterative XLEN-cycle path as above.

Test Plan:
- Reset mid-CALC: assert rst during cycle 10 of a DIV → state IDLE, stall=0, done=0, result=0 immediately (asynchronous).
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD):
  - result=0xFFFFFFEB with done in cycle k+33 (k+1 with MULDIV_FAST_MUL_EN).
  - MULH on the same operands → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; stall high for 33 cycles, done 1 cycle.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; each with done in cycle k+1.
- Flush at CALC cycle 5 of DIV → no done pulse, back to IDLE; new DIVU 9/3 next cycle → result 3, rd_addr_out equals new rd_addr.
- Back-to-back ops: second start arrives the cycle after DONE → accepted; first result unchanged until second DONE.

Source files
------------

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier instead of the iterative multiply.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [2:0]       op;
    logic [4:0]       rd_q;
    logic [XLEN-1:0]  opnd;
    logic [XLEN-1:0]  acc_hi;
    logic [XLEN-1:0]  acc_lo;
    logic             neg_main;
    logic             neg_rem;

    logic             is_div_in;
    logic             rs1_signed;
    logic             rs2_signed;
    logic             s1;
    logic             s2;
    logic [XLEN-1:0]  abs1;
    logic [XLEN-1:0]  abs2;
    logic             div_zero;
    logic             div_ovf;
    logic             direct;
    logic [XLEN-1:0]  special_res;
    logic [XLEN-1:0]  direct_res;
    logic             accept;
    logic             last;

    // Operand decode for the op currently presented by ID/EX
    always_comb begin
        is_div_in   = funct3[2];
        rs1_signed  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        rs2_signed  = funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
        s1          = rs1_signed & rs1_data[XLEN-1];
        s2          = rs2_signed & rs2_data[XLEN-1];
        abs1        = s1 ? -rs1_data : rs1_data;
        abs2        = s2 ? -rs2_data : rs2_data;
        div_zero    = is_div_in && (rs2_data == '0);
        div_ovf     = is_div_in && !funct3[0] &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? rs1_data : '1;
        end else begin
            special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] ext1;
    logic [2*XLEN-1:0] ext2;
    logic [2*XLEN-1:0] fast_prod;

    // Sign/zero extension to 2*XLEN makes a plain truncated product correct for every signedness
    always_comb begin
        ext1       = rs1_signed ? {{XLEN{rs1_data[XLEN-1]}}, rs1_data} : {{XLEN{1'b0}}, rs1_data};
        ext2       = rs2_signed ? {{XLEN{rs2_data[XLEN-1]}}, rs2_data} : {{XLEN{1'b0}}, rs2_data};
        fast_prod  = ext1 * ext2;
        direct     = div_zero || div_ovf || !is_div_in;
        direct_res = special_res;
        if (!is_div_in) begin
            direct_res = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
    end
`else
    always_comb begin
        direct     = div_zero || div_ovf;
        direct_res = special_res;
    end
`endif

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   hi_n;
    logic [XLEN-1:0]   lo_n;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   calc_res;

    // One radix-2 step; acc_lo holds the multiplier (multiply) or the shifting quotient (divide)
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        if (op[2]) begin
            hi_n = div_ge ? (div_shift[XLEN-1:0] - opnd) : div_shift[XLEN-1:0];
            lo_n = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
        prod_fix = neg_main ? -{hi_n, lo_n} : {hi_n, lo_n};
        q_fix    = neg_main ? -lo_n : lo_n;
        r_fix    = neg_rem ? -hi_n : hi_n;
        if (op[2]) begin
            calc_res = op[1] ? r_fix : q_fix;
        end else begin
            calc_res = (op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end
        last = (cnt == CNT_W'(XLEN-1));
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    accept    = 1'b1;
                    stall     = 1'b1;
                    state_nxt = direct ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                    if (last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result and rd_addr_out only change on entry to DONE, so they hold across flushed ops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            op          <= '0;
            rd_q        <= '0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            neg_main    <= 1'b0;
            neg_rem     <= 1'b0;
            result      <= '0;
            rd_addr_out <= '0;
        end else if (accept) begin
            op       <= funct3;
            rd_q     <= rd_addr;
            cnt      <= '0;
            neg_main <= s1 ^ s2;
            neg_rem  <= s1;
            acc_hi   <= '0;
            if (is_div_in) begin
                opnd   <= abs2;
                acc_lo <= abs1;
            end else begin
                opnd   <= abs1;
                acc_lo <= abs2;
            end
            if (direct) begin
                result      <= direct_res;
                rd_addr_out <= rd_addr;
            end
        end else if (state == CALC && !flush) begin
            cnt    <= cnt + CNT_W'(1);
            acc_hi <= hi_n;
            acc_lo <= lo_n;
            if (last) begin
                result      <= calc_res;
                rd_addr_out <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M corner cases plus randomized ops against an arithmetic model.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_addr_out;

    int          checks;
    int          errors;
    logic [31:0] prev_result;

    ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .funct3      (funct3),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rd_addr     (rd_addr),
        .flush       (flush),
        .stall       (stall),
        .done        (done),
        .result      (result),
        .rd_addr_out (rd_addr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics from 64-bit arithmetic
    function automatic logic [31:0] refResult(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        t  = '0;
        case (f3)
            3'd0: t = sa * sb;
            3'd1: begin t = sa * sb; t = t >> 32; end
            3'd2: begin t = sa * longint'(ub); t = t >> 32; end
            3'd3: begin t = ua * ub; t = t >> 32; end
            3'd4: begin
                if (b == 32'd0) t = 64'hFFFF_FFFF;
                else t = sa / sb;
            end
            3'd5: begin
                if (b == 32'd0) t = 64'hFFFF_FFFF;
                else t = ua / ub;
            end
            3'd6: begin
                if (b == 32'd0) t = ua;
                else t = sa % sb;
            end
            default: begin
                if (b == 32'd0) t = ua;
                else t = ua % ub;
            end
        endcase
        return t[31:0];
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return 33;
    endfunction

    // Presents one op in the current (IDLE) cycle and follows it through done
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input string name);
        logic [31:0] exp_res;
        int          exp_lat;
        int          n;
        int          stall_cnt;
        int          hold_bad;
        exp_res   = refResult(f3, a, b);
        exp_lat   = refLatency(f3, a, b);
        start     = 1'b1;
        funct3    = f3;
        rs1_data  = a;
        rs2_data  = b;
        rd_addr   = rd;
        #1;
        stall_cnt = stall ? 1 : 0;
        hold_bad  = 0;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_addr  = 5'($urandom);
        n = 1;
        while (!done && n < 100) begin
            if (stall) stall_cnt++;
            if (result !== prev_result) hold_bad++;
            @(negedge clk);
            n++;
        end
        checkOutput({name, ":done"}, 32'(done), 32'd1);
        checkOutput({name, ":latency"}, 32'(n), 32'(exp_lat));
        checkOutput({name, ":stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
        checkOutput({name, ":stall_at_done"}, 32'(stall), 32'd0);
        checkOutput({name, ":result_hold"}, 32'(hold_bad), 32'd0);
        checkOutput({name, ":result"}, result, exp_res);
        checkOutput({name, ":rd"}, 32'(rd_addr_out), 32'(rd));
        @(negedge clk);
        checkOutput({name, ":pulse"}, 32'(done), 32'd0);
        prev_result = exp_res;
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks      = 0;
        errors      = 0;
        prev_result = '0;
        rst         = 1'b1;
        start       = 1'b0;
        flush       = 1'b0;
        funct3      = '0;
        rs1_data    = '0;
        rs2_data    = '0;
        rd_addr     = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset:stall", 32'(stall), 32'd0);
        checkOutput("reset:done", 32'(done), 32'd0);
        checkOutput("reset:result", result, 32'd0);
        checkOutput("reset:rd", 32'(rd_addr_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back directed ops: each starts the cycle after the previous DONE
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, "mul");
        applyStimulus(3'd1, 32'd7, 32'hFFFF_FFFD, 5'd2, "mulh");
        applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhu");
        applyStimulus(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, "mulhsu");
        applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, "div");
        applyStimulus(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, "rem");
        applyStimulus(3'd5, 32'd100, 32'd7, 5'd7, "divu");
        applyStimulus(3'd7, 32'd100, 32'd7, 5'd8, "remu");
        applyStimulus(3'd5, 32'd5, 32'd0, 5'd9, "divu_zero");
        applyStimulus(3'd6, 32'd5, 32'd0, 5'd10, "rem_zero");
        applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "rem_ovf");
        applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "div_ovf");

        // Flush during the fifth CALC cycle, then a new op the next cycle
        start    = 1'b1;
        funct3   = 3'd4;
        rs1_data = 32'd1000;
        rs2_data = 32'd7;
        rd_addr  = 5'd13;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("flush:stall", 32'(stall), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush:done", 32'(done), 32'd0);
        checkOutput("flush:idle_stall", 32'(stall), 32'd0);
        applyStimulus(3'd5, 32'd9, 32'd3, 5'd21, "divu_after_flush");

        // Flush alongside start in IDLE must not accept the op
        start    = 1'b1;
        flush    = 1'b1;
        funct3   = 3'd5;
        rs1_data = 32'd5;
        rs2_data = 32'd0;
        rd_addr  = 5'd30;
        #1;
        checkOutput("idle_flush:stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("idle_flush:done", 32'(done), 32'd0);
        checkOutput("idle_flush:stall_after", 32'(stall), 32'd0);
        checkOutput("idle_flush:rd", 32'(rd_addr_out), 32'd21);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand(),
                          5'($urandom), $sformatf("rand%0d", i));
        end

        // Asynchronous reset in the tenth CALC cycle of a divide
        start    = 1'b1;
        funct3   = 3'd4;
        rs1_data = 32'd12345;
        rs2_data = 32'd67;
        rd_addr  = 5'd17;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midreset:stall", 32'(stall), 32'd0);
        checkOutput("midreset:done", 32'(done), 32'd0);
        checkOutput("midreset:result", result, 32'd0);
        checkOutput("midreset:rd", 32'(rd_addr_out), 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        prev_result = '0;
        @(negedge clk);
        applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd31, "mul_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
